mem_port_arbiter: RTL and testbench

- Shares one single-ported memory bus between the core's instruction-fetch port and data (load/store) port.
- Sequences each access as a request/acknowledge transaction on the memory side and generates the core-side fetch-valid, data-stall and fault/error signals.
- Sits between the RV32I core and the unified instruction/data memory model or controller.
- Data accesses have priority over fetches, with a starvation guard so fetches are still served.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between the instruction-fetch and data ports.
// Data wins by default. A starvation counter forces a fetch through after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_wmask,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  input  logic        m_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_I_BUSY, S_D_BUSY, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic        r_m_req, r_m_we, r_sel_i, r_err, r_killed;
  logic [3:0]  r_m_wmask;
  logic [31:0] r_m_addr, r_m_wdata, r_if_inst, r_d_rdata;

  logic w_i_pend, w_force_i, w_grant_d, w_grant_i, w_misalign;
  logic w_busy, w_timeout, w_done, w_fail, w_resp, w_d_done;

  always_comb begin
    w_i_pend   = if_req & ~if_kill;
    w_force_i  = w_i_pend & (r_starve == SW'(STARVE_MAX));
    w_grant_d  = (r_state == S_IDLE) & d_req & ~w_force_i;
    w_grant_i  = (r_state == S_IDLE) & w_i_pend & ~w_grant_d;
    w_misalign = (if_addr[1:0] != 2'b00);
    w_busy     = (r_state == S_I_BUSY) | (r_state == S_D_BUSY);
    w_timeout  = (r_tmo == TW'(TIMEOUT - 1));
    w_done     = w_busy & (m_err | m_ack | w_timeout);
    // m_err dominates m_ack; completing without either means the timeout fired.
    w_fail     = m_err | ~m_ack;
    w_resp     = (r_state == S_RESP);
    w_d_done   = w_resp & ~r_sel_i;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d)      w_next = S_D_BUSY;
        else if (w_grant_i) w_next = w_misalign ? S_RESP : S_I_BUSY;
      end
      S_I_BUSY, S_D_BUSY: if (w_done) w_next = S_RESP;
      S_RESP:             w_next = S_IDLE;
      default:            w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_starve  <= '0;
      r_tmo     <= '0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_wmask <= 4'h0;
      r_m_addr  <= 32'h0;
      r_m_wdata <= 32'h0;
      r_sel_i   <= 1'b0;
      r_err     <= 1'b0;
      r_killed  <= 1'b0;
      r_if_inst <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      r_state <= w_next;

      if (!if_req || w_grant_i)
        r_starve <= '0;
      else if (w_grant_d && r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + SW'(1);

      if (w_grant_d) begin
        r_m_req   <= 1'b1;
        r_m_we    <= d_we;
        r_m_wmask <= d_wmask;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
        r_sel_i   <= 1'b0;
        r_err     <= 1'b0;
        r_killed  <= 1'b0;
        r_tmo     <= '0;
      end else if (w_grant_i) begin
        r_sel_i  <= 1'b1;
        r_killed <= 1'b0;
        r_tmo    <= '0;
        r_err    <= w_misalign;
        if (!w_misalign) begin
          r_m_req   <= 1'b1;
          r_m_we    <= 1'b0;
          r_m_wmask <= 4'hF;
          r_m_addr  <= if_addr;
          r_m_wdata <= 32'h0;
        end
      end else if (w_busy) begin
        if (w_done) begin
          r_m_req <= 1'b0;
          r_err   <= w_fail;
          if (!w_fail) begin
            if (r_sel_i)      r_if_inst <= m_rdata;
            else if (!r_m_we) r_d_rdata <= m_rdata;
          end
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end

      // A kill anywhere in the fetch's lifetime suppresses its response.
      if (r_state != S_IDLE && r_sel_i && if_kill)
        r_killed <= 1'b1;
    end
  end

  always_comb begin
    m_req    = r_m_req;
    m_we     = r_m_we;
    m_wmask  = r_m_wmask;
    m_addr   = r_m_addr;
    m_wdata  = r_m_wdata;
    if_inst  = r_if_inst;
    d_rdata  = r_d_rdata;
    if_valid = w_resp & r_sel_i & ~r_killed & ~if_kill;
    if_fault = if_valid & r_err;
    d_stall  = d_req & ~w_d_done;
    d_err    = w_d_done & r_err;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, load/store, starvation order, kill, timeout, misalign, mid-access reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_inst;
  logic        if_valid, if_fault;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_wmask = 4'h0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_stall, d_err;
  logic        m_req, m_we;
  logic [3:0]  m_wmask;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ack = 1'b0, m_err = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_inst(if_inst), .if_valid(if_valid), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got %b exp 0", m_req); end
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL reset_d_stall got %b exp 0", d_stall); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b exp 0", if_valid); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h exp 0", d_rdata); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h exp 0", if_inst); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1;
    checks++; if (d_stall !== 1'b1 || m_req !== 1'b0) begin errors++; $display("FAIL load_c0 got stall=%b mreq=%b exp 1/0", d_stall, m_req); end
    cyc();
    m_ack = 1'b1; m_rdata = 32'h03020100;
    #1;
    checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h100) begin errors++; $display("FAIL load_c1 got req=%b we=%b addr=%h exp 1/0/100", m_req, m_we, m_addr); end
    checks++; if (d_stall !== 1'b1) begin errors++; $display("FAIL load_c1_stall got %b exp 1", d_stall); end
    cyc();
    m_ack = 1'b0;
    #1;
    checks++; if (d_stall !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL load_c2 got stall=%b mreq=%b exp 0/0", d_stall, m_req); end
    checks++; if (d_rdata !== 32'h03020100) begin errors++; $display("FAIL load_rdata got %h exp 03020100", d_rdata); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", d_err); end
    d_req = 1'b0;
    cyc();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      m_ack = (i == 4);
      #1;
      checks++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_wmask !== 4'b0011 || m_wdata !== 32'hAABBCCDD || m_addr !== 32'h20 || d_stall !== 1'b1) begin
        errors++;
        $display("FAIL store_c%0d got req=%b we=%b mask=%b wdata=%h stall=%b exp 1/1/0011/aabbccdd/1", i, m_req, m_we, m_wmask, m_wdata, d_stall);
      end
    end
    cyc();
    m_ack = 1'b0;
    #1;
    checks++; if (d_stall !== 1'b0 || m_req !== 1'b0 || d_err !== 1'b0) begin errors++; $display("FAIL store_done got stall=%b mreq=%b err=%b exp 0/0/0", d_stall, m_req, d_err); end
    checks++; if (d_rdata !== 32'h03020100) begin errors++; $display("FAIL store_rdata_kept got %h exp 03020100", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;
    cyc();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [10];
    logic [31:0] got_addr [10];
    int ngrant = 0;
    int nvalid = 0;
    for (int i = 0; i < 10; i++) exp_addr[i] = ((i % 5) == 4) ? 32'h200 : 32'h300;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    m_ack = 1'b1; m_rdata = 32'h00000013;
    for (int c = 0; c < 30; c++) begin
      cyc();
      #1;
      if (m_req && ngrant < 10) begin got_addr[ngrant] = m_addr; ngrant++; end
      if (if_valid) nvalid++;
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc(); cyc(); cyc();
    m_ack = 1'b0;
    checks++; if (ngrant !== 10) begin errors++; $display("FAIL starve_grants got %0d exp 10", ngrant); end
    for (int i = 0; i < ngrant; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL starve_order[%0d] got %h exp %h", i, got_addr[i], exp_addr[i]); end
    end
    checks++; if (nvalid !== 2) begin errors++; $display("FAIL starve_fetches got %0d exp 2", nvalid); end
    checks++; if (d_rdata !== 32'h13) begin errors++; $display("FAIL starve_rdata got %h exp 13", d_rdata); end
  endtask

  task automatic test_kill();
    if_req = 1'b1; if_addr = 32'h40;
    cyc();
    if_kill = 1'b1;
    #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0 || m_wmask !== 4'hF) begin errors++; $display("FAIL kill_issue got req=%b addr=%h we=%b mask=%h exp 1/40/0/f", m_req, m_addr, m_we, m_wmask); end
    cyc();
    if_kill = 1'b0; if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h00000013;
    cyc();
    m_ack = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || if_fault !== 1'b0) begin errors++; $display("FAIL kill_suppress got valid=%b fault=%b exp 0/0", if_valid, if_fault); end
    cyc();
    if_req = 1'b1; if_addr = 32'h80;
    cyc();
    m_ack = 1'b1; m_rdata = 32'h00100093;
    #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h80) begin errors++; $display("FAIL fetch80_issue got req=%b addr=%h exp 1/80", m_req, m_addr); end
    cyc();
    m_ack = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b1 || if_fault !== 1'b0 || if_inst !== 32'h00100093) begin errors++; $display("FAIL fetch80_resp got valid=%b fault=%b inst=%h exp 1/0/00100093", if_valid, if_fault, if_inst); end
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int busy = 0;
    logic seen_done = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; m_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      #1;
      if (!d_stall) begin
        seen_done = 1'b1;
        checks++; if (d_err !== 1'b1 || m_req !== 1'b0) begin errors++; $display("FAIL tmo_done got err=%b mreq=%b exp 1/0", d_err, m_req); end
        break;
      end
      if (m_req) busy++;
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL tmo_bound got no completion exp completion within 40 cycles"); end
    checks++; if (busy !== 16) begin errors++; $display("FAIL tmo_busy got %0d exp 16", busy); end
    checks++; if (d_rdata !== 32'h13) begin errors++; $display("FAIL tmo_rdata_kept got %h exp 13", d_rdata); end
    d_req = 1'b0;
    cyc();
  endtask

  task automatic test_misaligned();
    if_req = 1'b1; if_addr = 32'h42;
    cyc();
    #1;
    checks++; if (if_valid !== 1'b1 || if_fault !== 1'b1 || m_req !== 1'b0) begin errors++; $display("FAIL misalign got valid=%b fault=%b mreq=%b exp 1/1/0", if_valid, if_fault, m_req); end
    if_req = 1'b0;
    cyc();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL misalign_after got mreq=%b exp 0", m_req); end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; m_ack = 1'b0;
    cyc();
    #1;
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got mreq=%b exp 1", m_req); end
    reset = 1'b1; d_req = 1'b0;
    cyc();
    #1;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_drop got mreq=%b exp 0", m_req); end
    reset = 1'b0; m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      checks++;
      if (d_rdata !== 32'h0 || d_err !== 1'b0 || if_valid !== 1'b0 || d_stall !== 1'b0 || m_req !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_late_ack[%0d] got rdata=%h err=%b valid=%b stall=%b mreq=%b exp 0/0/0/0/0", c, d_rdata, d_err, if_valid, d_stall, m_req);
      end
    end
    m_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_starvation();
    test_kill();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
